fir_tdm_sequencer: RTL

- Control sequencer for the time-multiplexed 64-tap FIR filter.
- Each accepted input sample is written into a circular sample RAM. The block then walks taps 0..N-1 over N consecutive cycles, driving the sample-RAM read address and the coefficient select that indexes the packed Q1.15 coefficient bus.
- Strobes the shared single multiply-accumulate unit (first-tap clear, accumulate enable), aligned to the datapath latencies.
- Presents the finished result with a valid/ready handshake.

---
 rtl/fir_tdm_pkg.sv | 18 +
 rtl/fir_tdm_strobe_delay.sv | 26 ++
 rtl/fir_tdm_sequencer.sv | 130 +++++++++++++
 3 files changed

// File: rtl/fir_tdm_pkg.sv
// Shared constants, state encoding and latency helper for the TDM FIR sequencer.
package fir_tdm_pkg;
   localparam int N_DEF  = 64;
   localparam int AW_DEF = $clog2(N_DEF);
   localparam int COEF_W = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      HOLD  = 2'd3
   } state_t;

   // Cycle, counted from the handshake cycle, in which out_valid first rises.
   function automatic int out_cycle(input int n, input int rd_lat, input int mac_lat);
      return n + rd_lat + mac_lat;
   endfunction
endpackage

// File: rtl/fir_tdm_strobe_delay.sv
// Delays the {clr, en} MAC strobe pair by DEPTH cycles to line up with operand arrival.
module fir_tdm_strobe_delay #(
   parameter int DEPTH = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] d,
   output logic [1:0] q
);
   if (DEPTH == 0) begin : g_wire
      assign q = d;
   end else begin : g_pipe
      logic [1:0] pipe [DEPTH];

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
         end else begin
            pipe[0] <= d;
            for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
         end
      end

      assign q = pipe[DEPTH-1];
   end
endmodule

// File: rtl/fir_tdm_sequencer.sv
// Control sequencer for a time-multiplexed FIR: sample write, tap walk, MAC strobes, output handshake.
//
//   state | meaning
//   IDLE  | waiting for an input sample, in_ready high
//   RUN   | walking taps 0..N-1, one per cycle
//   DRAIN | waiting for the last product to reach the accumulator output
//   HOLD  | out_valid high until the consumer takes it
module fir_tdm_sequencer
   import fir_tdm_pkg::*;
#(
   parameter int N       = N_DEF,
   parameter int AW      = $clog2(N),
   parameter int RD_LAT  = 1,
   parameter int MAC_LAT = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   output logic          wr_en,
   output logic [AW-1:0] wr_addr,
   output logic [AW-1:0] rd_addr,
   output logic [AW-1:0] tap_idx,
   output logic          mac_en,
   output logic          mac_clr,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          busy
);
   // DRAIN spans the cycles between the last RUN cycle and the out_valid cycle.
   localparam int         DRAIN_CYC = out_cycle(N, RD_LAT, MAC_LAT) - N - 1;
   localparam logic [3:0] DRAIN_LD  = 4'(DRAIN_CYC - 1);

   state_t        state;
   logic [AW-1:0] wptr;
   logic [AW-1:0] k;
   logic [AW-1:0] rd_q;
   logic [3:0]    dcnt;
   logic          i_en;
   logic          i_clr;
   logic          ir_q;
   logic          ov_q;
   logic          busy_q;
   logic          hs;
   logic [1:0]    strb;

   assign hs        = in_valid & ir_q;
   assign wr_en     = hs;
   assign in_ready  = ir_q;
   assign wr_addr   = wptr;
   assign rd_addr   = rd_q;
   assign tap_idx   = k;
   assign out_valid = ov_q;
   assign busy      = busy_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         wptr   <= '0;
         k      <= '0;
         rd_q   <= '0;
         dcnt   <= '0;
         i_en   <= 1'b0;
         i_clr  <= 1'b0;
         ir_q   <= 1'b0;
         ov_q   <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (hs) begin
                  wptr   <= wptr + AW'(1);
                  rd_q   <= wptr;
                  k      <= '0;
                  i_en   <= 1'b1;
                  i_clr  <= 1'b1;
                  ir_q   <= 1'b0;
                  busy_q <= 1'b1;
                  state  <= RUN;
               end else begin
                  ir_q <= 1'b1;
               end
            end
            RUN: begin
               i_clr <= 1'b0;
               if (k == AW'(N - 1)) begin
                  i_en <= 1'b0;
                  if (DRAIN_CYC == 0) begin
                     ov_q  <= 1'b1;
                     state <= HOLD;
                  end else begin
                     dcnt  <= DRAIN_LD;
                     state <= DRAIN;
                  end
               end else begin
                  k    <= k + AW'(1);
                  rd_q <= rd_q - AW'(1);
               end
            end
            DRAIN: begin
               if (dcnt == 4'd0) begin
                  ov_q  <= 1'b1;
                  state <= HOLD;
               end else begin
                  dcnt <= dcnt - 4'd1;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  ov_q   <= 1'b0;
                  busy_q <= 1'b0;
                  ir_q   <= 1'b1;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   fir_tdm_strobe_delay #(.DEPTH(RD_LAT)) u_strobe (
      .clk (clk),
      .rst (rst),
      .d   ({i_clr, i_en}),
      .q   (strb)
   );

   assign mac_en  = strb[0];
   assign mac_clr = strb[1];
endmodule
